pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the dual-issue in-order pipeline. It merges per-stage stall requests and the two issue-slot special stalls into the frontend and backend write enables and per-slot kill strobes. It also sequences branch-mispredict recovery: it latches the redirect, pulses it to F1, and holds a bounded flush window over the F2/decode/issue buffers. It sits beside the pipeline register block and drives its enables, and it keeps stall and flush performance counters.

## Interface

Parameters:
- FLUSH_CYCLES, 2, number of cycles `flush_front_o` stays high after an accepted redirect; legal range 1..15.

Ports (clock and reset first):
- clock_i  in  1  system clock, all state on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- f1_stall_i, f2_stall_i, dec_stall_i, exec_stall_i, mem_stall_i, wb_stall_i  in  1 each  stage stall requests.
- issue0_special_stall_i, issue1_special_stall_i  in  1 each  slot-specific issue hazard.
- exec_wrong_branch_i  in  1  mispredict resolved in execute this cycle.
- exec_redirect_pc_i  in  32  correct target, valid with `exec_wrong_branch_i`.
- backend_we_o  out  1  enables every pipeline register from decode/issue onward.
- frontend_we_o  out  1  enables F1 PC and the F1/F2 and F2/decode buffers.
- issue0_kill_o, issue1_kill_o  out  1 each  insert a bubble in issue slot 0 or 1.
- flush_front_o  out  1  clear the F2, decode and issue buffers.
- redirect_valid_o  out  1  one-cycle pulse that loads the F1 PC.
- redirect_pc_o  out  32  target PC, stable while `redirect_valid_o` is high and held afterwards.
- state_o  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH.
- stall_cycles_o  out  32  count of cycles with `backend_we_o` low; saturates at 0xFFFFFFFF.
- flush_count_o  out  16  count of accepted redirects; wraps modulo 2^16.

## Operation

- Define hold = OR of all six stage stall inputs.
- `backend_we_o` = !hold. This is combinational in every state.
- Issue stalls:
  - istall0 = issue0_special_stall_i & !hold & (state != FLUSH).
  - istall1 = issue1_special_stall_i & !hold & (state != FLUSH).
- Kills:
  - `issue0_kill_o` = istall1.
  - `issue1_kill_o` = istall0.
  - The stalled slot keeps its buffer; the other slot gets a bubble.
- `frontend_we_o` = !hold & !istall0 & !istall1.
- `flush_front_o` = (state == FLUSH).

FSM:
- RUN
  - If hold, go to STALL.
  - Else if exec_wrong_branch_i, accept the redirect.
- STALL
  - If exec_wrong_branch_i is seen, set the pending bit and latch the PC. A later wrong-branch pulse overwrites both.
  - When hold drops:
    - If pending, accept the redirect using the latched PC and clear pending.
    - Else return to RUN.
- FLUSH
  - Counter loaded with FLUSH_CYCLES on entry.
  - Counter decrements only on cycles where hold is low.
  - exec_wrong_branch_i is ignored; execute holds only bubbles.
  - When the counter reaches 1 with hold low, go to RUN (or to STALL if hold rises that same cycle).
- Accepting a redirect means, at the next edge:
  - redirect_pc_o <= target.
  - redirect_valid_o <= 1.
  - flush_count_o increments.
  - counter <= FLUSH_CYCLES.
  - state <= FLUSH.
- Counters:
  - stall_cycles_o increments each cycle hold is high, including cycles in FLUSH, and saturates.
  - flush_count_o wraps.

## Timing

- Reset values of all outputs and state:
  - backend_we_o = 1, frontend_we_o = 1.
  - kills = 0, flush_front_o = 0, redirect_valid_o = 0, redirect_pc_o = 0.
  - state_o = 0, stall_cycles_o = 0, flush_count_o = 0.
  - pending = 0, counter = 0.
- `backend_we_o`, `frontend_we_o` and the kills are zero-latency combinational outputs.
- Redirect and flush timing:
  - A wrong branch at cycle T with hold low gives `redirect_valid_o` = 1 in T+1 only.
  - `flush_front_o` is high for cycles T+1 .. T+FLUSH_CYCLES when hold is low throughout.
  - That window extends by one cycle per cycle of hold.
- A wrong branch during hold gives `redirect_valid_o` in the cycle after hold falls.
- Reset asserted mid-FLUSH or mid-STALL returns to RUN immediately (asynchronously) and discards pending.
- Both issue special stalls together: frontend_we_o = 0 and both kills = 1; the pipeline register block treats kill as priority over enable.

## Test plan

- Reset release, no stalls, 10 cycles:
  - backend_we_o = frontend_we_o = 1 throughout.
  - state_o = 0, stall_cycles_o = 0.
- mem_stall_i high for 3 cycles:
  - backend_we_o = frontend_we_o = 0 for those 3 cycles.
  - state_o = 1 from the second of those cycles, back to 0 the cycle after stall_i falls.
  - stall_cycles_o = 3.
- issue1_special_stall_i high for 1 cycle:
  - issue0_kill_o = 1, issue1_kill_o = 0, frontend_we_o = 0, backend_we_o = 1 in that cycle.
- exec_wrong_branch_i with target 0x0000_0200 at T, FLUSH_CYCLES = 2:
  - redirect_valid_o = 1 with PC 0x200 at T+1 only.
  - flush_front_o high in T+1 and T+2.
  - state_o = 2 then 0; flush_count_o = 1.
- Redirect during hold:
  - dec_stall_i high in T..T+2, wrong branch with target 0x0000_0300 at T+1.
  - redirect_valid_o = 1 with PC 0x300 at T+4.
  - A second wrong branch pulse during FLUSH causes no new pulse and flush_count_o stays 1.
- reset_i asserted at T+2 of a FLUSH:
  - In the same cycle: state_o = 0, flush_front_o = 0, counters = 0.
  - No redirect_valid_o after reset release.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the dual-issue in-order pipeline
// Merges stage stalls into pipeline enables/kills and sequences mispredict recovery.
module pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        f1_stall_i,
  input  logic        f2_stall_i,
  input  logic        dec_stall_i,
  input  logic        exec_stall_i,
  input  logic        mem_stall_i,
  input  logic        wb_stall_i,
  input  logic        issue0_special_stall_i,
  input  logic        issue1_special_stall_i,
  input  logic        exec_wrong_branch_i,
  input  logic [31:0] exec_redirect_pc_i,
  output logic        backend_we_o,
  output logic        frontend_we_o,
  output logic        issue0_kill_o,
  output logic        issue1_kill_o,
  output logic        flush_front_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_count_o
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  logic [1:0]  state_q, state_d;
  logic        pending_q, pending_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic [31:0] accept_pc;
  logic        hold, istall0, istall1;

  assign hold = f1_stall_i | f2_stall_i | dec_stall_i | exec_stall_i | mem_stall_i | wb_stall_i;
  assign state_o = state_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= S_RUN;
      pending_q        <= 1'b0;
      pend_pc_q        <= 32'd0;
      cnt_q            <= 4'd0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= 32'd0;
      stall_cycles_o   <= 32'd0;
      flush_count_o    <= 16'd0;
    end else begin
      state_q          <= state_d;
      pending_q        <= pending_d;
      pend_pc_q        <= pend_pc_d;
      cnt_q            <= cnt_d;
      redirect_valid_o <= accept;
      if (accept) begin
        redirect_pc_o <= accept_pc;
        flush_count_o <= flush_count_o + 16'd1;
      end
      if (hold && stall_cycles_o != 32'hFFFF_FFFF)
        stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    pend_pc_d = pend_pc_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    accept_pc = pend_pc_q;
    case (state_q)
      S_RUN: begin
        if (hold) begin
          state_d = S_STALL;
          if (exec_wrong_branch_i) begin
            pending_d = 1'b1;
            pend_pc_d = exec_redirect_pc_i;
          end
        end else if (exec_wrong_branch_i) begin
          accept    = 1'b1;
          accept_pc = exec_redirect_pc_i;
        end
      end
      S_STALL: begin
        if (hold) begin
          if (exec_wrong_branch_i) begin
            pending_d = 1'b1;
            pend_pc_d = exec_redirect_pc_i;
          end
        end else if (exec_wrong_branch_i) begin
          // a fresh mispredict in the release cycle supersedes the latched one
          accept    = 1'b1;
          accept_pc = exec_redirect_pc_i;
        end else if (pending_q) begin
          accept = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        if (!hold) begin
          if (cnt_q <= 4'd1) begin
            state_d = S_RUN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = S_RUN;
    endcase
    if (accept) begin
      state_d   = S_FLUSH;
      cnt_d     = FLUSH_INIT;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    istall0       = issue0_special_stall_i & !hold & (state_q != S_FLUSH);
    istall1       = issue1_special_stall_i & !hold & (state_q != S_FLUSH);
    backend_we_o  = !hold;
    frontend_we_o = !hold & !istall0 & !istall1;
    issue0_kill_o = istall1;
    issue1_kill_o = istall0;
    flush_front_o = (state_q == S_FLUSH);
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed plus randomized bench for pipeline_ctrl
// Reference model tracks remaining flush cycles and a pending redirect, not FSM states.
module tb_pipeline_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f1 = 0, f2 = 0, dec = 0, ex = 0, mem = 0, wb = 0;
  logic        sp0 = 0, sp1 = 0, wbr = 0;
  logic [31:0] tpc = 0;
  logic        backend_we, frontend_we, kill0, kill1, flush_front, rv;
  logic [31:0] rpc, stall_cycles;
  logic [1:0]  state;
  logic [15:0] flush_count;

  int total = 0;
  int bad = 0;

  int          m_frem;
  bit          m_was_hold, m_pend, m_rv;
  logic [31:0] m_ppc, m_rpc, m_sc;
  logic [15:0] m_fc;

  pipeline_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clock_i(clk), .reset_i(rst),
    .f1_stall_i(f1), .f2_stall_i(f2), .dec_stall_i(dec),
    .exec_stall_i(ex), .mem_stall_i(mem), .wb_stall_i(wb),
    .issue0_special_stall_i(sp0), .issue1_special_stall_i(sp1),
    .exec_wrong_branch_i(wbr), .exec_redirect_pc_i(tpc),
    .backend_we_o(backend_we), .frontend_we_o(frontend_we),
    .issue0_kill_o(kill0), .issue1_kill_o(kill1),
    .flush_front_o(flush_front), .redirect_valid_o(rv), .redirect_pc_o(rpc),
    .state_o(state), .stall_cycles_o(stall_cycles), .flush_count_o(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_frem = 0; m_was_hold = 0; m_pend = 0; m_rv = 0;
    m_ppc = 0; m_rpc = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic set_in(input bit s_f1, input bit s_dec, input bit s_mem,
                        input bit s_sp0, input bit s_sp1, input bit s_wbr, input logic [31:0] s_pc);
    f1 = s_f1; f2 = 0; dec = s_dec; ex = 0; mem = s_mem; wb = 0;
    sp0 = s_sp0; sp1 = s_sp1; wbr = s_wbr; tpc = s_pc;
  endtask

  // Check the current cycle at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    bit hold, flushing, is0, is1;
    hold = f1 | f2 | dec | ex | mem | wb;
    flushing = (m_frem > 0);
    is0 = sp0 && !hold && !flushing;
    is1 = sp1 && !hold && !flushing;
    @(negedge clk);
    chk("backend_we", backend_we, !hold);
    chk("frontend_we", frontend_we, !hold && !is0 && !is1);
    chk("kill0", kill0, is1);
    chk("kill1", kill1, is0);
    chk("flush_front", flush_front, flushing);
    chk("state", state, flushing ? 2 : (m_was_hold ? 1 : 0));
    chk("redirect_valid", rv, m_rv);
    chk("redirect_pc", rpc, m_rpc);
    chk("stall_cycles", stall_cycles, m_sc);
    chk("flush_count", flush_count, m_fc);
    @(posedge clk);
    m_rv = 0;
    if (hold && m_sc != 32'hFFFF_FFFF) m_sc++;
    if (flushing) begin
      if (!hold) m_frem--;
      m_was_hold = 0;
    end else if (hold) begin
      if (wbr) begin m_pend = 1; m_ppc = tpc; end
      m_was_hold = 1;
    end else begin
      if (wbr || m_pend) begin
        m_rpc = wbr ? tpc : m_ppc;
        m_rv = 1; m_fc++; m_frem = FC; m_pend = 0;
      end
      m_was_hold = 0;
    end
    #1;
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_backend_we", backend_we, 1);
    chk("rst_frontend_we", frontend_we, 1);
    chk("rst_state", state, 0);
    chk("rst_redirect_pc", rpc, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    @(posedge clk); #1 rst = 0;

    // idle run
    for (int i = 0; i < 10; i++) begin set_in(0,0,0,0,0,0,0); cycle(); end

    // mem stall for three cycles
    for (int i = 0; i < 3; i++) begin set_in(0,0,1,0,0,0,0); cycle(); end
    set_in(0,0,0,0,0,0,0); cycle();
    chk("plan_stall_count", stall_cycles, 3);
    cycle();

    // single issue1 special stall, then both at once
    set_in(0,0,0,0,1,0,0); cycle();
    set_in(0,0,0,1,1,0,0); cycle();

    // wrong branch to 0x200 with no hold
    set_in(0,0,0,0,0,1,32'h200); cycle();
    chk("plan_rpc_200", rpc, 32'h200);
    chk("plan_rv_200", rv, 1);
    set_in(0,0,0,0,0,0,0);
    for (int i = 0; i < 3; i++) cycle();
    chk("plan_fc_1", flush_count, 1);

    // redirect during hold, then an ignored one during flush
    set_in(0,1,0,0,0,0,0); cycle();
    set_in(0,1,0,0,0,1,32'h300); cycle();
    set_in(0,1,0,0,0,0,0); cycle();
    set_in(0,0,0,0,0,0,0); cycle();
    chk("plan_rpc_300", rpc, 32'h300);
    set_in(0,0,0,0,0,1,32'h400); cycle();
    set_in(0,0,0,0,0,0,0);
    for (int i = 0; i < 3; i++) cycle();
    chk("plan_fc_2", flush_count, 2);
    chk("plan_rpc_held", rpc, 32'h300);

    // asynchronous reset in the middle of a flush
    set_in(0,0,0,0,0,1,32'h500); cycle();
    set_in(0,0,0,0,0,0,0); cycle();
    #2 rst = 1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_flush_front", flush_front, 0);
    chk("midrst_stall_cycles", stall_cycles, 0);
    chk("midrst_flush_count", flush_count, 0);
    chk("midrst_rv", rv, 0);
    model_reset();
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 4; i++) cycle();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      f1  = ($urandom_range(0, 15) == 0);
      f2  = ($urandom_range(0, 15) == 0);
      dec = ($urandom_range(0, 15) == 0);
      ex  = ($urandom_range(0, 15) == 0);
      mem = ($urandom_range(0, 15) == 0);
      wb  = ($urandom_range(0, 15) == 0);
      sp0 = ($urandom_range(0, 3) == 0);
      sp1 = ($urandom_range(0, 3) == 0);
      wbr = ($urandom_range(0, 5) == 0);
      tpc = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
